// File: rtl/uart_pkg.sv
// Shared UART package: frame constants, transmitter state encoding and a
// parity helper. The receiver reuses the constants and the baud counter.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the producer (master) and the UART transmitter
// (slave). A byte moves when tx_valid_i && tx_ready_o at a rising clock edge.
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] tx_data_i;
    logic                      tx_valid_i;
    logic                      tx_ready_o;

    modport master (
        output tx_data_i,
        output tx_valid_i,
        input  tx_ready_o
    );

    modport slave (
        input  tx_data_i,
        input  tx_valid_i,
        output tx_ready_o
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Counts while en is high; bit_end marks the last cycle of a bit period,
// after which the counter wraps to zero. clear forces it back to zero.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic en,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;

    assign bit_end = en && (cnt_r == LAST_CNT);

    // Count cycles within the current bit; wrap at the bit boundary.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if (clear || bit_end) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one byte over a valid/ready handshake and
// serializes it LSB first on tx_o as start + 8 data + stop (8N1).
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// before the stop bit (8E1). All outputs come straight from registers.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic     clk_i,
    input  logic     rst_i,
    uart_tx_if.slave tx_if,
    output logic     tx_o,
    output logic     tx_busy_o,
    output logic     tx_done_o
);

    uart_tx_state_t            state_r;
    uart_tx_state_t            state_nxt_s;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic [UART_DATA_BITS-1:0] shift_nxt_s;
    logic [2:0]                idx_r;
    logic [2:0]                idx_nxt_s;
    logic                      tx_r;
    logic                      tx_nxt_s;
    logic                      ready_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      done_nxt_s;
    logic                      accept_s;
    logic                      bit_end_s;
    logic                      baud_clear_s;
`ifdef UART_TX_PARITY_EN
    logic                      parity_r;
    logic                      parity_nxt_s;
`endif

    // Ready is high exactly when the FSM sits in IDLE, so this is the acceptance.
    assign accept_s     = tx_if.tx_valid_i && ready_r;
    assign baud_clear_s = (state_r == IDLE);

    assign tx_if.tx_ready_o = ready_r;
    assign tx_o             = tx_r;
    assign tx_busy_o        = busy_r;
    assign tx_done_o        = done_r;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (baud_clear_s),
        .en     (!baud_clear_s),
        .bit_end(bit_end_s)
    );

    // Next-state, next-line-level and datapath decisions for the frame FSM.
    always_comb begin
        state_nxt_s  = state_r;
        shift_nxt_s  = shift_r;
        idx_nxt_s    = idx_r;
        tx_nxt_s     = tx_r;
        done_nxt_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt_s = parity_r;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s  = START;
                    shift_nxt_s  = tx_if.tx_data_i;
                    idx_nxt_s    = 3'd0;
                    tx_nxt_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_nxt_s = even_parity(tx_if.tx_data_i);
`endif
                end else begin
                    tx_nxt_s = 1'b1;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_nxt_s = DATA;
                    tx_nxt_s    = shift_r[0];
                end else begin
                    tx_nxt_s = 1'b0;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_nxt_s = {1'b0, shift_r[UART_DATA_BITS-1:1]};
                    if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt_s = PARITY;
                        tx_nxt_s    = parity_r;
`else
                        state_nxt_s = STOP;
                        tx_nxt_s    = 1'b1;
`endif
                    end else begin
                        idx_nxt_s = idx_r + 3'd1;
                        tx_nxt_s  = shift_r[1];
                    end
                end else begin
                    tx_nxt_s = shift_r[0];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    state_nxt_s = STOP;
                    tx_nxt_s    = 1'b1;
                end else begin
                    tx_nxt_s = parity_r;
                end
            end
`endif
            STOP: begin
                if (bit_end_s) begin
                    state_nxt_s = IDLE;
                    tx_nxt_s    = 1'b1;
                    done_nxt_s  = 1'b1;
                end else begin
                    tx_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                tx_nxt_s    = 1'b1;
            end
        endcase
    end

    // FSM state, shift register, bit index and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= IDLE;
            shift_r  <= '0;
            idx_r    <= 3'd0;
            tx_r     <= 1'b1;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            shift_r  <= shift_nxt_s;
            idx_r    <= idx_nxt_s;
            tx_r     <= tx_nxt_s;
            ready_r  <= (state_nxt_s == IDLE);
            busy_r   <= (state_nxt_s != IDLE);
            done_r   <= done_nxt_s;
`ifdef UART_TX_PARITY_EN
            parity_r <= parity_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx with CLKS_PER_BIT = 4. Inputs change and
// outputs are sampled on the falling edge. Cycle c is the cycle following
// rising edge c-1, where edge 0 is the acceptance edge.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int L = NBITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic busy;
    logic done;
    int   checks = 0;
    int   errors = 0;

    uart_tx_if tx_if ();

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .tx_if    (tx_if),
        .tx_o     (tx),
        .tx_busy_o(busy),
        .tx_done_o(done)
    );

    always #5 clk = ~clk;

    // Expected {tx, busy, done, ready} in cycle c (1..L+1) of a frame carrying d.
    function automatic logic [3:0] exp_vec(input int c, input logic [7:0] d);
        int k;
        if (c <= CPB) return 4'b0100;
        if (c <= 9 * CPB) begin
            k = (c - CPB - 1) / CPB;
            return {d[k], 3'b100};
        end
        if (c <= L) begin
            if (NBITS == 11 && c <= 10 * CPB) return {^d, 3'b100};
            return 4'b1100;
        end
        return 4'b1011;
    endfunction

    // Offer a byte; returns in cycle 1 of its frame (valid still high).
    task automatic offer(input logic [7:0] d);
        @(negedge clk);
        tx_if.tx_data_i  = d;
        tx_if.tx_valid_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [3:0] got;
        rst = 1'b1;
        tx_if.tx_valid_i = 1'b0;
        tx_if.tx_data_i  = 8'h00;
        repeat (3) @(negedge clk);
        got = {tx, busy, done, tx_if.tx_ready_o};
        checks++;
        if (got !== 4'b1001) begin
            errors++;
            $display("FAIL reset_held: got %b expected 1001", got);
        end
        rst = 1'b0;
        @(negedge clk);
        got = {tx, busy, done, tx_if.tx_ready_o};
        checks++;
        if (got !== 4'b1001) begin
            errors++;
            $display("FAIL reset_released: got %b expected 1001", got);
        end
    endtask

    task automatic test_single_byte;
        logic [3:0] got, e;
        logic [9:0] seq;
`ifdef UART_TX_PARITY_EN
        logic [9:0] seq_exp = 10'b0101001010;
`else
        logic [9:0] seq_exp = 10'b1101001010;
`endif
        seq = '0;
        offer(8'hA5);
        for (int c = 1; c <= L + 1; c++) begin
            if (c > 1) @(negedge clk);
            got = {tx, busy, done, tx_if.tx_ready_o};
            e = exp_vec(c, 8'hA5);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL single_byte cycle %0d: got %b expected %b", c, got, e);
            end
            if (c % CPB == 2 && c <= 10 * CPB) seq[c / CPB] = tx;
            if (c == 1) tx_if.tx_valid_i = 1'b0;
        end
        checks++;
        if (seq !== seq_exp) begin
            errors++;
            $display("FAIL single_byte_bits: got %b expected %b", seq, seq_exp);
        end
    endtask

    task automatic test_data_stability;
        logic [3:0] got, e;
        logic [9:0] seq;
`ifdef UART_TX_PARITY_EN
        logic [9:0] seq_exp = 10'b0101001010;
`else
        logic [9:0] seq_exp = 10'b1101001010;
`endif
        seq = '0;
        offer(8'hA5);
        for (int c = 1; c <= L + 1; c++) begin
            if (c > 1) @(negedge clk);
            got = {tx, busy, done, tx_if.tx_ready_o};
            e = exp_vec(c, 8'hA5);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL data_stability cycle %0d: got %b expected %b", c, got, e);
            end
            if (c % CPB == 2 && c <= 10 * CPB) seq[c / CPB] = tx;
            if (c == 1) tx_if.tx_valid_i = 1'b0;
            if (c == 2) tx_if.tx_data_i = 8'h00;
        end
        checks++;
        if (seq !== seq_exp) begin
            errors++;
            $display("FAIL data_stability_bits: got %b expected %b", seq, seq_exp);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] got, e;
        int idle_cycles;
        idle_cycles = 0;
        offer(8'h55);
        for (int c = 1; c <= 2 * L + 2; c++) begin
            if (c > 1) @(negedge clk);
            got = {tx, busy, done, tx_if.tx_ready_o};
            if (c <= L + 1) e = exp_vec(c, 8'h55);
            else            e = exp_vec(c - L - 1, 8'h0F);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", c, got, e);
            end
            if (c >= 2 && c <= 2 * L + 1 && !busy) idle_cycles++;
            if (c == L + 1) tx_if.tx_data_i = 8'h0F;
            if (c == L + 2) tx_if.tx_valid_i = 1'b0;
        end
        checks++;
        if (idle_cycles !== 1) begin
            errors++;
            $display("FAIL back_to_back_gap: got %0d idle cycles expected 1", idle_cycles);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [3:0] got, e;
        logic done_seen;
        offer(8'h00);
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 1) tx_if.tx_valid_i = 1'b0;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame_pre: got tx %b expected 0", tx);
        end
        #1 rst = 1'b1;
        #1 got = {tx, busy, done, tx_if.tx_ready_o};
        checks++;
        if (got !== 4'b1001) begin
            errors++;
            $display("FAIL mid_frame_async: got %b expected 1001", got);
        end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 2 * L; c++) begin
            @(negedge clk);
            if (done || !tx) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame_quiet: got activity %b expected 0", done_seen);
        end
        offer(8'h3C);
        for (int c = 1; c <= L + 1; c++) begin
            if (c > 1) @(negedge clk);
            got = {tx, busy, done, tx_if.tx_ready_o};
            e = exp_vec(c, 8'h3C);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL after_reset cycle %0d: got %b expected %b", c, got, e);
            end
            if (c == 1) tx_if.tx_valid_i = 1'b0;
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] bytes [2]  = '{8'hA5, 8'h07};
        logic       pbit  [2]  = '{1'b0, 1'b1};
        logic [3:0] got, e;
        for (int b = 0; b < 2; b++) begin
            offer(bytes[b]);
            for (int c = 1; c <= L + 1; c++) begin
                if (c > 1) @(negedge clk);
                got = {tx, busy, done, tx_if.tx_ready_o};
                e = exp_vec(c, bytes[b]);
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL parity_frame %h cycle %0d: got %b expected %b", bytes[b], c, got, e);
                end
                if (c == 38) begin
                    checks++;
                    if (tx !== pbit[b]) begin
                        errors++;
                        $display("FAIL parity_bit %h: got %b expected %b", bytes[b], tx, pbit[b]);
                    end
                end
                if (c == 45) begin
                    checks++;
                    if (done !== 1'b1) begin
                        errors++;
                        $display("FAIL parity_done %h: got %b expected 1", bytes[b], done);
                    end
                end
                if (c == 1) tx_if.tx_valid_i = 1'b0;
            end
        end
    endtask
`endif

    initial begin
        tx_if.tx_valid_i = 1'b0;
        tx_if.tx_data_i  = 8'h00;
        test_reset();
        test_single_byte();
        test_data_stability();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
